// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed DIGITS-digit hex 7-segment driver with frame-synchronous
//           update, leading-zero suppression, decimal points and anti-ghost blanking.
// Latency : seg/dp/an are registered, 1 clk after the prescaler/index state they show.
// Flow    : no backpressure; load is accepted on any clock, including while disabled.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - synchronous active-low reset
//   value   - 4*DIGITS hex value, nibble i -> digit i (digit 0 least significant)
//   dp_in   - per-digit decimal-point request
//   load    - capture value/dp_in into the shadow registers
//   lz_en   - leading-zero suppression enable
//   enable  - display enable; 0 freezes scanning and blanks the outputs
//   seg     - segments, bit 6 = a .. bit 0 = g (polarity per SEG_ACTIVE_LOW)
//   dp      - decimal point (polarity per SEG_ACTIVE_LOW)
//   an      - digit strobes, at most one active (polarity per AN_ACTIVE_LOW)
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

  // Inactive output levels for each polarity choice.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Hex nibble to active-high segment pattern {a,b,c,d,e,f,g}.
  function automatic logic [6:0] f_hex_to_seg(input logic [3:0] i_nib);
    logic [6:0] v_seg;
    case (i_nib)
      4'h0:    v_seg = 7'b1111110;
      4'h1:    v_seg = 7'b0110000;
      4'h2:    v_seg = 7'b1101101;
      4'h3:    v_seg = 7'b1111001;
      4'h4:    v_seg = 7'b0110011;
      4'h5:    v_seg = 7'b1011011;
      4'h6:    v_seg = 7'b1011111;
      4'h7:    v_seg = 7'b1110000;
      4'h8:    v_seg = 7'b1111111;
      4'h9:    v_seg = 7'b1111011;
      4'hA:    v_seg = 7'b1110111;
      4'hB:    v_seg = 7'b0011111;
      4'hC:    v_seg = 7'b1001110;
      4'hD:    v_seg = 7'b0111101;
      4'hE:    v_seg = 7'b1001111;
      default: v_seg = 7'b1000111;
    endcase
    return v_seg;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;

  // Shadow holds the latest load; frame holds what the current scan frame shows.
  logic [4*DIGITS-1:0] r_shadow_val;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [4*DIGITS-1:0] r_frame_val;
  logic [DIGITS-1:0]   r_frame_dp;

  // Registered outputs
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  // Combinational view of the digit currently being scanned
  logic [3:0]          w_nib;
  logic                w_dp_frame;
  logic                w_upper_zero;
  logic                w_blank_digit;
  logic [6:0]          w_seg_raw;
  logic [6:0]          w_seg_lvl;
  logic                w_dp_lvl;
  logic [DIGITS-1:0]   w_an_onehot;
  logic [DIGITS-1:0]   w_an_lvl;
  logic                w_presc_wrap;
  logic                w_idx_last;
  logic                w_strobe;

  always_comb begin
    w_nib        = 4'h0;
    w_dp_frame   = 1'b0;
    w_upper_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib      = r_frame_val[4*i +: 4];
        w_dp_frame = r_frame_dp[i];
        // Digit 0 is never a leading zero, so only i>0 can report upper-zero.
        w_upper_zero = (i != 0) && ((r_frame_val >> (4*i)) == '0);
      end
    end
  end

  assign w_blank_digit = lz_en && w_upper_zero;
  assign w_seg_raw     = w_blank_digit ? 7'b0000000 : f_hex_to_seg(w_nib);
  assign w_seg_lvl     = SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  // dp follows the frame bit even on a blanked digit.
  assign w_dp_lvl      = SEG_ACTIVE_LOW ? ~w_dp_frame : w_dp_frame;

  assign w_an_onehot   = AN_ONE << r_idx;
  assign w_an_lvl      = AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;

  assign w_presc_wrap  = (r_presc == CNT_LAST);
  assign w_idx_last    = (r_idx == IDX_LAST);
  // Leading part of every slot keeps all anodes dark so the segment bus can
  // settle on the new digit without ghosting onto the previous one.
  assign w_strobe      = (r_presc >= BLANK_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_frame_val  <= '0;
      r_frame_dp   <= '0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_an         <= AN_OFF;
    end else begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end

      if (enable) begin
        if (w_presc_wrap) begin
          r_presc <= '0;
          if (w_idx_last) begin
            // Start of frame: the frame copy sees the pre-edge shadow, so a
            // load on this same edge waits for the following frame.
            r_idx       <= '0;
            r_frame_val <= r_shadow_val;
            r_frame_dp  <= r_shadow_dp;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end else begin
          r_presc <= r_presc + CNT_W'(1);
        end

        // Frame data and index only move on a slot wrap, so seg/dp settle
        // while the anodes are still in the blank window.
        r_seg <= w_seg_lvl;
        r_dp  <= w_dp_lvl;
        r_an  <= w_strobe ? w_an_lvl : AN_OFF;
      end else begin
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
        r_an  <= AN_OFF;
      end
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, CLK_DIV=4, BLANK_CYC=1.
// u_dut uses default polarity (seg active high, an active low); u_pol uses
// inverted polarity and receives identical stimulus.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic        enable;

  logic [6:0]  seg,   seg_p;
  logic        dp,    dp_p;
  logic [3:0]  an,    an_p;

  int n_checks = 0;
  int n_errors = 0;
  int k        = 0;   // negedges seen since reset release

  // Hand-written segment codes {a..g} for hex digits 0..F.
  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Anode pattern over one 16-clock frame, starting at a slot boundary.
  logic [3:0] scan_tbl [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110,
    4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011,
    4'b1111, 4'b0111, 4'b0111, 4'b0111
  };

  seg7_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .enable(enable), .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .enable(enable), .seg(seg_p), .dp(dp_p), .an(an_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Shadow captures on the rising edge that ends negedge count j-1.
  task automatic do_load(input int j, input logic [15:0] v, input logic [3:0] d);
    run_to(j - 1);
    value = v;
    dp_in = d;
    load  = 1'b1;
    run_to(j);
    load  = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int kk, input int d,
                            input logic [6:0] exp_seg, input logic exp_dp);
    logic [3:0] on;
    logic [3:0] an_lo;
    logic [6:0] seg_inv;
    logic       dp_inv;
    run_to(kk);
    on      = 4'b0001 << d;
    an_lo   = ~on;
    seg_inv = ~exp_seg;
    dp_inv  = ~exp_dp;
    check_eq({tag, "_an"},    32'(an),    32'(an_lo));
    check_eq({tag, "_seg"},   32'(seg),   32'(exp_seg));
    check_eq({tag, "_dp"},    32'(dp),    32'(exp_dp));
    check_eq({tag, "_p_an"},  32'(an_p),  32'(on));
    check_eq({tag, "_p_seg"}, 32'(seg_p), 32'(seg_inv));
    check_eq({tag, "_p_dp"},  32'(dp_p),  32'(dp_inv));
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, "_an"},    32'(an),    32'h0000000F);
    check_eq({tag, "_seg"},   32'(seg),   32'h00000000);
    check_eq({tag, "_dp"},    32'(dp),    32'h00000000);
    check_eq({tag, "_p_an"},  32'(an_p),  32'h00000000);
    check_eq({tag, "_p_seg"}, 32'(seg_p), 32'h0000007F);
    check_eq({tag, "_p_dp"},  32'(dp_p),  32'h00000001);
  endtask

  initial begin
    logic [15:0] vals [4];
    logic [3:0]  dps  [4];
    logic [15:0] v;
    logic [3:0]  dv;

    vals = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    dps  = '{4'b0001, 4'b1010, 4'b0000, 4'b1111};

    // Reset held 3 clocks with enable and load high; load must not win.
    rst_n  = 1'b0;
    enable = 1'b1;
    load   = 1'b1;
    value  = 16'hFFFF;
    dp_in  = 4'hF;
    lz_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_off("reset");
    rst_n = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    dp_in = 4'h0;
    k     = 0;

    // First edge after release shows the blank window of digit 0 (frame is 0).
    run_to(1);
    check_eq("rel_k1_an",  32'(an),  32'h0000000F);
    check_eq("rel_k1_seg", 32'(seg), 32'(seg_tbl[0]));
    run_to(2);
    check_eq("rel_k2_an",  32'(an),  32'h0000000E);

    // Decode sweep: frame f+1 shows the value loaded during frame f.
    for (int f = 0; f < 4; f++) begin
      do_load(16*(f+1) - 1, vals[f], dps[f]);
      v  = vals[f];
      dv = dps[f];
      for (int d = 0; d < 4; d++)
        check_slot($sformatf("dec_f%0d_d%0d", f+1, d), 16*(f+1) + 4*d + 2, d,
                   seg_tbl[v[4*d +: 4]], dv[d]);
    end

    // Scan timing over one full frame (value FEDC steady).
    for (int o = 0; o < 16; o++) begin
      run_to(81 + o);
      check_eq($sformatf("scan_o%0d", o), 32'(an), 32'(scan_tbl[o]));
    end

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(111, 16'h0040, 4'b1000);
    check_slot("lz_d0", 114, 0, 7'b1111110, 1'b0);
    check_slot("lz_d1", 118, 1, 7'b0110011, 1'b0);
    check_slot("lz_d2", 122, 2, 7'b0000000, 1'b0);
    check_slot("lz_d3", 126, 3, 7'b0000000, 1'b1);
    do_load(127, 16'h0000, 4'b0000);
    check_slot("lz0_d0", 130, 0, 7'b1111110, 1'b0);
    check_slot("lz0_d1", 134, 1, 7'b0000000, 1'b0);
    check_slot("lz0_d2", 138, 2, 7'b0000000, 1'b0);
    check_slot("lz0_d3", 142, 3, 7'b0000000, 1'b0);
    lz_en = 1'b0;

    // Tear-free update: AAAA loaded during digit 2 of a 1111 frame.
    do_load(143, 16'h1111, 4'b0000);
    check_slot("tear_d0", 146, 0, 7'b0110000, 1'b0);
    check_slot("tear_d1", 150, 1, 7'b0110000, 1'b0);
    do_load(154, 16'hAAAA, 4'b0000);
    check_slot("tear_d2", 155, 2, 7'b0110000, 1'b0);
    check_slot("tear_d3", 158, 3, 7'b0110000, 1'b0);
    for (int d = 0; d < 4; d++)
      check_slot($sformatf("newA_d%0d", d), 162 + 4*d, d, 7'b1110111, 1'b0);

    // Load on the frame-copy edge is seen one frame later.
    do_load(176, 16'h5555, 4'b0000);
    check_slot("wrap_old_d0", 178, 0, 7'b1110111, 1'b0);
    check_slot("wrap_old_d3", 190, 3, 7'b1110111, 1'b0);
    check_slot("wrap_new_d0", 194, 0, 7'b1011011, 1'b0);
    check_slot("wrap_new_d3", 206, 3, 7'b1011011, 1'b0);

    // Enable dropped mid-slot of digit 1; load while disabled.
    check_slot("en_pre", 214, 1, 7'b1011011, 1'b0);
    enable = 1'b0;
    run_to(215);
    check_off("dis_k215");
    do_load(217, 16'h9999, 4'b0010);
    run_to(219);
    check_off("dis_k219");
    enable = 1'b1;
    check_slot("res_p2", 220, 1, 7'b1011011, 1'b0);
    check_slot("res_p3", 221, 1, 7'b1011011, 1'b0);
    run_to(222);
    check_eq("res_blank_an", 32'(an), 32'h0000000F);
    check_slot("res_d2",  223, 2, 7'b1011011, 1'b0);
    check_slot("res_d3",  227, 3, 7'b1011011, 1'b0);
    check_slot("dload_d0", 231, 0, 7'b1111011, 1'b0);
    check_slot("dload_d1", 235, 1, 7'b1111011, 1'b1);
    check_slot("dload_d3", 243, 3, 7'b1111011, 1'b0);

    // Reset mid-slot leaves no residual strobe.
    run_to(244);
    check_eq("mid_pre_an", 32'(an), 32'h00000007);
    rst_n = 1'b0;
    run_to(245);
    check_off("mid_reset");
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
